fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 31 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding, id-width
// helper and the {id, data} layout of a FIFO write word.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 16;

  // Width of a source id for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // The id sits directly above the beat data in fifo_wr_data.
  function automatic int wr_id_lsb(input int dw);
    return dw;
  endfunction

  function automatic int wr_id_msb(input int dw, input int idw);
    return dw + idw - 1;
  endfunction

  function automatic int wr_data_msb(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set request found when scanning
// from start upwards, wrapping modulo N. Purely combinational.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  int              pos;
  logic [IW-1:0]   pos_idx;

  // Scan from the farthest offset back to start so the nearest hit wins.
  always_comb begin
    idx     = '0;
    any     = |req;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_idx = IW'(pos);
      if (req[pos_idx]) begin
        idx = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, with
// packet lock so a granted requester keeps the port until its last beat.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int DW  = DEF_DW,
  parameter int IDW = id_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DW-1:0]   req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DW+IDW-1:0] fifo_wr_data,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  localparam int ID_LSB   = wr_id_lsb(DW);
  localparam int ID_MSB   = wr_id_msb(DW, IDW);
  localparam int DATA_MSB = wr_data_msb(DW);

  // Handshake: a beat of requester i transfers in the cycle where
  // req_valid[i] and req_ready[i] are both high; req_ready also drives
  // fifo_wr_en, so every transfer is exactly one FIFO write.

  arb_state_e     state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [IDW-1:0] owner, owner_n;
  logic [15:0]    pkt_count_n;

  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [IDW-1:0] grant;
  logic           grant_valid;
  logic           grant_last;
  logic           accept;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] p);
    return (int'(p) == N - 1) ? '0 : p + IDW'(1);
  endfunction

  fifo_wr_arbiter_rr_pick #(
    .N  (N),
    .IW (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // In LOCK the owner is the only candidate, even while its valid is low.
  always_comb begin
    grant       = pick_idx;
    grant_valid = pick_any;
    if (state == LOCK) begin
      grant       = owner;
      grant_valid = req_valid[owner];
    end
    grant_last = req_last[grant];
    accept     = grant_valid & ~fifo_full & rst_n;
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = accept;
    fifo_wr_data = '0;
    busy         = rst_n & (state == LOCK);
    if (accept) begin
      req_ready[grant] = 1'b1;
    end
    if (rst_n) begin
      fifo_wr_data[ID_MSB:ID_LSB] = grant;
      fifo_wr_data[DATA_MSB:0]    = req_data[int'(grant)*DW +: DW];
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    pkt_count_n = pkt_count;
    case (state)
      IDLE: begin
        if (accept && grant_last) begin
          rr_ptr_n    = ptr_after(grant);
          pkt_count_n = pkt_count + 16'd1;
        end else if (accept) begin
          state_n = LOCK;
          owner_n = grant;
        end
      end
      LOCK: begin
        if (accept && grant_last) begin
          state_n     = IDLE;
          rr_ptr_n    = ptr_after(owner);
          pkt_count_n = pkt_count + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      pkt_count <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      pkt_count <= pkt_count_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the committing rising edge.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW+IDW-1:0] fifo_wr_data;
  logic              busy;
  logic [15:0]       pkt_count;

  int          errors;
  int          checks;
  logic [15:0] exp_pkt;

  fifo_wr_arbiter #(
    .N   (N),
    .DW  (DW),
    .IDW (IDW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    req_valid[i]         = v;
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, DW'(16'h0F0 + i), 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b wr_en=%b busy=%b required ready=0000 wr_en=0 busy=0",
               req_ready, fifo_wr_en, busy);
    end
    checks++;
    if (fifo_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_wr_data: got %h required 0", fifo_wr_data);
    end
    checks++;
    if (pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_pkt_count: got %0d required 0", pkt_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_reqs();
    exp_pkt = 16'd0;
  endtask

  // All four hold single beats; rr_ptr starts at 0.
  task automatic test_round_robin();
    logic [IDW-1:0]    id;
    logic [DW+IDW-1:0] exp_word;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, DW'(16'h100 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      id       = IDW'(k % N);
      exp_word = {id, DW'(16'h100 + (k % N))};
      #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || req_ready !== 4'(1 << (k % N)) || fifo_wr_data !== exp_word) begin
        errors++;
        $display("FAIL rr_beat%0d: wr_en=%b ready=%b data=%h required wr_en=1 ready=%b data=%h",
                 k, fifo_wr_en, req_ready, fifo_wr_data, 4'(1 << (k % N)), exp_word);
      end
      exp_pkt = exp_pkt + 16'd1;
      @(negedge clk);
    end
    clear_reqs();
    #1;
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL rr_pkt_count: got %0d required %0d", pkt_count, exp_pkt);
    end
  endtask

  // rr_ptr is 1: req1 sends A1,A2,A3 while req2 waits with a single beat.
  task automatic test_packet_lock();
    logic [DW-1:0] beat_data [3];
    beat_data[0] = 16'h00A1;
    beat_data[1] = 16'h00A2;
    beat_data[2] = 16'h00A3;
    set_req(2, 1'b1, 16'h00B0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      set_req(1, 1'b1, beat_data[b], (b == 2));
      #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0010 || fifo_wr_data !== {2'd1, beat_data[b]}
          || busy !== (b != 0)) begin
        errors++;
        $display("FAIL lock_beat%0d: wr_en=%b ready=%b data=%h busy=%b required 1 0010 %h %b",
                 b, fifo_wr_en, req_ready, fifo_wr_data, busy, {2'd1, beat_data[b]}, (b != 0));
      end
      @(negedge clk);
    end
    exp_pkt = exp_pkt + 16'd1;
    set_req(1, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0100 || fifo_wr_data !== {2'd2, 16'h00B0} || busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: ready=%b data=%h busy=%b required 0100 %h 0",
               req_ready, fifo_wr_data, busy, {2'd2, 16'h00B0});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    clear_reqs();
  endtask

  // rr_ptr is 3: req0 sends C1,C2 with the FIFO full for 5 cycles in between.
  task automatic test_full_stall();
    set_req(0, 1'b1, 16'h00C1, 1'b0);
    set_req(1, 1'b1, 16'h00D0, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0001 || fifo_wr_data !== {2'd0, 16'h00C1}) begin
      errors++;
      $display("FAIL stall_first: ready=%b data=%h required 0001 %h",
               req_ready, fifo_wr_data, {2'd0, 16'h00C1});
    end
    @(negedge clk);
    set_req(0, 1'b1, 16'h00C2, 1'b1);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d: wr_en=%b ready=%b busy=%b required 0 0000 1",
                 c, fifo_wr_en, req_ready, busy);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0001 || fifo_wr_data !== {2'd0, 16'h00C2}) begin
      errors++;
      $display("FAIL stall_resume: wr_en=%b ready=%b data=%h required 1 0001 %h",
               fifo_wr_en, req_ready, fifo_wr_data, {2'd0, 16'h00C2});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    set_req(0, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0010 || fifo_wr_data !== {2'd1, 16'h00D0}) begin
      errors++;
      $display("FAIL stall_next: ready=%b data=%h required 0010 %h",
               req_ready, fifo_wr_data, {2'd1, 16'h00D0});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    clear_reqs();
  endtask

  // rr_ptr is 2: req3 owns the port and drops valid for 2 cycles; req0 waits.
  task automatic test_gap();
    set_req(3, 1'b1, 16'h00F1, 1'b0);
    set_req(0, 1'b1, 16'h00E0, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000 || fifo_wr_data !== {2'd3, 16'h00F1}) begin
      errors++;
      $display("FAIL gap_first: ready=%b data=%h required 1000 %h",
               req_ready, fifo_wr_data, {2'd3, 16'h00F1});
    end
    @(negedge clk);
    set_req(3, 1'b0, 16'h0000, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_cycle%0d: wr_en=%b ready=%b busy=%b required 0 0000 1",
                 c, fifo_wr_en, req_ready, busy);
      end
      @(negedge clk);
    end
    set_req(3, 1'b1, 16'h00F2, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000 || fifo_wr_data !== {2'd3, 16'h00F2}) begin
      errors++;
      $display("FAIL gap_last: ready=%b data=%h required 1000 %h",
               req_ready, fifo_wr_data, {2'd3, 16'h00F2});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    set_req(3, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001 || fifo_wr_data !== {2'd0, 16'h00E0}) begin
      errors++;
      $display("FAIL gap_next: ready=%b data=%h required 0001 %h",
               req_ready, fifo_wr_data, {2'd0, 16'h00E0});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    clear_reqs();
    #1;
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL gap_pkt_count: got %0d required %0d", pkt_count, exp_pkt);
    end
  endtask

  // rr_ptr is 1: lock on req2, then a one-cycle reset with req0 and req2 valid.
  task automatic test_reset_mid_packet();
    set_req(2, 1'b1, 16'h0061, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_first: ready=%b required 0100", req_ready);
    end
    @(negedge clk);
    set_req(2, 1'b1, 16'h0062, 1'b0);
    set_req(0, 1'b1, 16'h0070, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || fifo_wr_data !== '0) begin
      errors++;
      $display("FAIL rstmid_during: ready=%b wr_en=%b busy=%b data=%h required 0000 0 0 0",
               req_ready, fifo_wr_en, busy, fifo_wr_data);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    exp_pkt = 16'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || pkt_count !== exp_pkt || req_ready !== 4'b0001
        || fifo_wr_data !== {2'd0, 16'h0070}) begin
      errors++;
      $display("FAIL rstmid_after: busy=%b pkt=%0d ready=%b data=%h required 0 %0d 0001 %h",
               busy, pkt_count, req_ready, fifo_wr_data, exp_pkt, {2'd0, 16'h0070});
    end
    exp_pkt = exp_pkt + 16'd1;
    @(negedge clk);
    clear_reqs();
  endtask

  // req0 alone sends single beats until the counter reaches 0xFFFF, then one more.
  task automatic test_counter_wrap();
    set_req(0, 1'b1, 16'h0055, 1'b1);
    while (exp_pkt != 16'hFFFF) begin
      @(negedge clk);
      exp_pkt = exp_pkt + 16'd1;
    end
    #1;
    checks++;
    if (pkt_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_max: got %h required ffff", pkt_count);
    end
    @(negedge clk);
    exp_pkt = exp_pkt + 16'd1;
    clear_reqs();
    #1;
    checks++;
    if (pkt_count !== 16'h0000 || exp_pkt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %h required 0000", pkt_count);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_pkt   = 16'd0;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_full_stall();
    test_gap();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
